// File: rtl/fp_sqrt_result_buffer.sv
// Result FIFO behind the non-stallable FP sqrt unit, with issue credits so the
// dispatcher never has more sqrt ops outstanding than the FIFO can hold.
module fp_sqrt_result_buffer #(
  parameter int FP_WIDTH   = 32,
  parameter int TAG_WIDTH  = 4,
  parameter int STAT_WIDTH = 5,
  parameter int DEPTH      = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         IssueEn_i,
  output logic                         IssueReady_o,
  input  logic                         SqrtValid_i,
  input  logic [FP_WIDTH-1:0]          SqrtRes_i,
  input  logic [TAG_WIDTH-1:0]         SqrtTag_i,
  input  logic [STAT_WIDTH-1:0]        SqrtStatus_i,
  output logic                         Valid_o,
  input  logic                         Ready_i,
  output logic [FP_WIDTH-1:0]          Res_o,
  output logic [TAG_WIDTH-1:0]         Tag_o,
  output logic [STAT_WIDTH-1:0]        Status_o,
  output logic [$clog2(DEPTH+1)-1:0]   Credits_o,
  output logic                         Overflow_o
);

  localparam int EW = FP_WIDTH + TAG_WIDTH + STAT_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH-1);

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic [CW-1:0] credits_reg, credits_next;
  logic          overflow_reg, overflow_next;
  logic [EW-1:0] entry_mem [DEPTH];
  logic [EW-1:0] head_data;

  logic issue, pop, push, full, valid;

  assign valid        = (count_reg != '0);
  assign full         = (count_reg == DEPTH_C);
  assign IssueReady_o = (credits_reg != '0);
  assign issue        = IssueEn_i & IssueReady_o;
  assign pop          = valid & Ready_i;
  // A full FIFO still accepts a result when the head leaves in the same cycle.
  assign push         = SqrtValid_i & (~full | pop);

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    credits_next  = credits_reg;
    overflow_next = overflow_reg | (SqrtValid_i & full & ~pop);

    if (push) wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
    if (pop)  rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;

    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase

    // issue already implies a nonzero credit; the pop side saturates at DEPTH.
    if (issue && !pop)
      credits_next = credits_reg - 1'b1;
    else if (pop && !issue && credits_reg != DEPTH_C)
      credits_next = credits_reg + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      credits_reg  <= DEPTH_C;
      overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      credits_reg  <= credits_next;
      overflow_reg <= overflow_next;
    end
  end

  // Storage carries no reset; stale contents are hidden by the valid gating below.
  always_ff @(posedge clk_i) begin
    if (push) entry_mem[wr_ptr_reg] <= {SqrtRes_i, SqrtTag_i, SqrtStatus_i};
  end

  assign head_data = valid ? entry_mem[rd_ptr_reg] : '0;

  assign {Res_o, Tag_o, Status_o} = head_data;
  assign Valid_o    = valid;
  assign Credits_o  = credits_reg;
  assign Overflow_o = overflow_reg;

endmodule

// File: tb/tb_fp_sqrt_result_buffer.sv
// Randomized bench: a queue-based FIFO/credit model plus a fixed 2-cycle sqrt
// pipeline model drive and check fp_sqrt_result_buffer every cycle.
module tb_fp_sqrt_result_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int SQRT_LAT = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          IssueEn_i;
  logic          IssueReady_o;
  logic          SqrtValid_i;
  logic [31:0]   SqrtRes_i;
  logic [3:0]    SqrtTag_i;
  logic [4:0]    SqrtStatus_i;
  logic          Valid_o;
  logic          Ready_i;
  logic [31:0]   Res_o;
  logic [3:0]    Tag_o;
  logic [4:0]    Status_o;
  logic [CW-1:0] Credits_o;
  logic          Overflow_o;

  fp_sqrt_result_buffer #(
    .FP_WIDTH(32), .TAG_WIDTH(4), .STAT_WIDTH(5), .DEPTH(DEPTH)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .IssueEn_i(IssueEn_i), .IssueReady_o(IssueReady_o),
    .SqrtValid_i(SqrtValid_i), .SqrtRes_i(SqrtRes_i), .SqrtTag_i(SqrtTag_i),
    .SqrtStatus_i(SqrtStatus_i),
    .Valid_o(Valid_o), .Ready_i(Ready_i), .Res_o(Res_o), .Tag_o(Tag_o),
    .Status_o(Status_o), .Credits_o(Credits_o), .Overflow_o(Overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  tag;
    logic [4:0]  st;
  } ent_t;

  typedef struct {
    int   due;
    ent_t e;
  } fl_t;

  ent_t model_q[$];
  fl_t  inflight[$];
  int   model_credits;
  bit   model_ovf;
  int   cyc;
  int   errors;
  int   checks;

  function automatic ent_t mk(input logic [31:0] r, input logic [3:0] t, input logic [4:0] s);
    ent_t e;
    e.res = r; e.tag = t; e.st = s;
    return e;
  endfunction

  function automatic ent_t rnd_ent();
    return mk($urandom, 4'($urandom), 5'($urandom));
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_state();
    check_eq("valid", 64'(Valid_o), 64'(model_q.size() != 0));
    if (model_q.size() != 0) begin
      check_eq("res", 64'(Res_o), 64'(model_q[0].res));
      check_eq("tag", 64'(Tag_o), 64'(model_q[0].tag));
      check_eq("status", 64'(Status_o), 64'(model_q[0].st));
    end
    check_eq("credits", 64'(Credits_o), 64'(model_credits));
    check_eq("issue_ready", 64'(IssueReady_o), 64'(model_credits != 0));
    check_eq("overflow", 64'(Overflow_o), 64'(model_ovf));
  endtask

  // One clock cycle: iss/rdy drive the handshakes, fv forces a sqrt result
  // (used only for protocol-violating scenarios), ie is the op issued now.
  task automatic tick(input bit iss, input bit rdy, input bit fv, input ent_t fe, input ent_t ie);
    ent_t sv_e;
    fl_t  f;
    bit   sv;
    bit   acc, pop, push, full_pre;
    sv = 1'b0;
    sv_e = rnd_ent();
    if (inflight.size() != 0 && inflight[0].due == cyc) begin
      f = inflight.pop_front();
      sv = 1'b1;
      sv_e = f.e;
    end else if (fv) begin
      sv = 1'b1;
      sv_e = fe;
    end
    acc      = iss && (model_credits != 0);
    pop      = (model_q.size() != 0) && rdy;
    full_pre = (model_q.size() == DEPTH);
    push     = sv && (!full_pre || pop);

    IssueEn_i    = iss;
    Ready_i      = rdy;
    SqrtValid_i  = sv;
    SqrtRes_i    = sv_e.res;
    SqrtTag_i    = sv_e.tag;
    SqrtStatus_i = sv_e.st;
    if (pop)
      $display("pop  cyc=%0d tag=%0d res=%08h status=%02h",
               cyc, model_q[0].tag, model_q[0].res, model_q[0].st);

    @(posedge clk_i);
    #1;
    if (pop) model_q.delete(0);
    if (push) model_q.push_back(sv_e);
    if (sv && full_pre && !pop) model_ovf = 1'b1;
    if (acc) begin
      f.due = cyc + SQRT_LAT;
      f.e   = ie;
      inflight.push_back(f);
    end
    if (acc && !pop) model_credits--;
    else if (pop && !acc && model_credits < DEPTH) model_credits++;
    cyc++;
    check_state();
  endtask

  task automatic idle(input bit rdy);
    tick(1'b0, rdy, 1'b0, rnd_ent(), rnd_ent());
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((model_q.size() != 0 || inflight.size() != 0) && n < 64) begin
      idle(1'b1);
      n++;
    end
    if (n >= 64) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got=%0d entries left expected=0", model_q.size());
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    #2;
    model_q.delete();
    inflight.delete();
    model_credits = DEPTH;
    model_ovf     = 1'b0;
    check_eq("rst_valid", 64'(Valid_o), 64'(0));
    check_eq("rst_credits", 64'(Credits_o), 64'(DEPTH));
    check_eq("rst_overflow", 64'(Overflow_o), 64'(0));
    check_eq("rst_res", 64'(Res_o), 64'(0));
    check_eq("rst_tag", 64'(Tag_o), 64'(0));
    check_eq("rst_status", 64'(Status_o), 64'(0));
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    check_eq("rst_issue_ready", 64'(IssueReady_o), 64'(1));
  endtask

  task automatic fill(input int tag0);
    for (int i = 0; i < DEPTH; i++)
      tick(1'b1, 1'b0, 1'b0, rnd_ent(), mk($urandom, 4'(tag0 + i), 5'(i)));
    for (int i = 0; i < SQRT_LAT; i++) idle(1'b0);
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0;
    model_credits = DEPTH; model_ovf = 1'b0;
    rst_i = 1'b1; IssueEn_i = 1'b0; Ready_i = 1'b0; SqrtValid_i = 1'b0;
    SqrtRes_i = '0; SqrtTag_i = '0; SqrtStatus_i = '0;
    #3;
    do_reset();

    // Single op
    tick(1'b1, 1'b1, 1'b0, rnd_ent(), mk(32'h4000_0000, 4'd3, 5'd0));
    idle(1'b1);
    idle(1'b1);
    check_eq("single_valid", 64'(Valid_o), 64'(1));
    check_eq("single_res", 64'(Res_o), 64'h4000_0000);
    drain();

    // Fill then drain in order
    fill(0);
    check_eq("fill_credits", 64'(Credits_o), 64'(0));
    check_eq("fill_ready", 64'(IssueReady_o), 64'(0));
    tick(1'b1, 1'b0, 1'b0, rnd_ent(), rnd_ent());
    drain();
    check_eq("fill_credits_back", 64'(Credits_o), 64'(DEPTH));

    // Full FIFO with simultaneous push and pop
    fill(4);
    tick(1'b0, 1'b1, 1'b1, mk(32'h3f80_0000, 4'd9, 5'd1), rnd_ent());
    check_eq("simul_overflow", 64'(Overflow_o), 64'(0));
    drain();

    // Wrap-around, Ready toggling
    begin
      int issued, n;
      bit will;
      issued = 0; n = 0;
      while ((issued < 10 || model_q.size() != 0 || inflight.size() != 0) && n < 200) begin
        will = (issued < 10) && (model_credits != 0);
        tick(issued < 10, n[0] == 1'b0, 1'b0, rnd_ent(), mk($urandom, 4'(issued), 5'(issued)));
        if (will) issued++;
        n++;
      end
      if (n >= 200) begin
        checks++; errors++;
        $display("FAIL wrap_timeout: got=%0d issued expected=10", issued);
      end
    end

    // Random traffic, including IssueEn while not ready
    for (int i = 0; i < 400; i++)
      tick($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, 1'b0, rnd_ent(), rnd_ent());
    drain();

    // Overflow: forced result into a full FIFO with no pop
    fill(8);
    tick(1'b0, 1'b0, 1'b1, mk(32'hdead_beef, 4'hE, 5'h1f), rnd_ent());
    check_eq("ovf_set", 64'(Overflow_o), 64'(1));
    idle(1'b0);
    drain();
    check_eq("ovf_sticky", 64'(Overflow_o), 64'(1));

    // Reset mid-operation: 2 stored, 1 in flight
    for (int i = 0; i < 3; i++)
      tick(1'b1, 1'b0, 1'b0, rnd_ent(), mk($urandom, 4'(i), 5'(i)));
    idle(1'b0);
    check_eq("midop_stored", 64'(model_q.size() == 2 && inflight.size() == 1), 64'(1));
    do_reset();
    for (int i = 0; i < 4; i++) idle(1'b1);
    tick(1'b1, 1'b1, 1'b0, rnd_ent(), mk(32'h4040_0000, 4'd5, 5'd2));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
